// File: rtl/calc_alu_sequencer_if.sv
// Request/response bundle for calc_alu_sequencer: operation request in, result and status out.
interface calc_alu_sequencer_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     rem;
    logic                 err;
    logic [CNT_W-1:0]     op_count;

    modport master (
        output start, op, a, b,
        input  busy, done, result, rem, err, op_count
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, rem, err, op_count
    );
endinterface

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer built around one shared adder/subtractor.
// Optional completed-operation counter enabled by defining CALC_OP_COUNT_EN.
module calc_alu_sequencer #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    calc_alu_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = WIDTH + 2;
    localparam int RW = 2 * WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    // Shared adder/subtractor, two bits wider than an operand so that a
    // subtraction of two (WIDTH+1)-bit unsigned values keeps a valid sign bit.
    logic [AW-1:0]    add_x, add_y, add_s;
    logic             add_sub;

    assign add_s = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        case (op_q)
            OP_ADD: begin
                add_x = {2'b00, a_q};
                add_y = {2'b00, b_q};
            end
            OP_SUB: begin
                add_x   = {2'b00, a_q};
                add_y   = {2'b00, b_q};
                add_sub = 1'b1;
            end
            OP_MUL: begin
                add_x = {2'b00, hi_q};
                add_y = lo_q[0] ? {2'b00, a_q} : '0;
            end
            default: begin
                add_x   = {1'b0, hi_q, lo_q[WIDTH-1]};
                add_y   = {2'b00, b_q};
                add_sub = 1'b1;
            end
        endcase
    end

    // Per-iteration next values for the {hi, lo} working pair.
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic             div_neg;

    assign mul_hi  = add_s[WIDTH:1];
    assign mul_lo  = {add_s[0], lo_q[WIDTH-1:1]};
    assign div_neg = add_s[AW-1];
    assign div_hi  = div_neg ? add_x[WIDTH-1:0] : add_s[WIDTH-1:0];
    assign div_lo  = {lo_q[WIDTH-2:0], ~div_neg};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = EXEC;
                    op_d     = bus.op;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    hi_d     = '0;
                    lo_d     = (bus.op == OP_MUL) ? bus.b : bus.a;
                    cnt_d    = CW'(WIDTH);
                    result_d = '0;
                    rem_d    = '0;
                    err_d    = 1'b0;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        result_d = {{(RW - AW){add_s[AW-1]}}, add_s};
                        cnt_d    = '0;
                        state_d  = DONE;
                    end
                    OP_MUL: begin
                        hi_d  = mul_hi;
                        lo_d  = mul_lo;
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_d = {mul_hi, mul_lo};
                            state_d  = DONE;
                        end
                    end
                    default: begin
                        if (b_q == '0) begin
                            err_d    = 1'b1;
                            result_d = '1;
                            rem_d    = a_q;
                            cnt_d    = '0;
                            state_d  = DONE;
                        end else begin
                            hi_d  = div_hi;
                            lo_d  = div_lo;
                            cnt_d = cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) begin
                                result_d = {{WIDTH{1'b0}}, div_lo};
                                rem_d    = div_hi;
                                state_d  = DONE;
                            end
                        end
                    end
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

`ifdef CALC_OP_COUNT_EN
    logic [CNT_W-1:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == DONE) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign bus.op_count = op_count_q;
`else
    assign bus.op_count = '0;
`endif

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.rem    = rem_q;
    assign bus.err    = err_q;
endmodule

// File: doc/calc_alu_sequencer.md
Name: calc_alu_sequencer

Overview:
- Multi-cycle operation controller for the calculator arithmetic core.
- Accepts one operation request at a time (add, sub, mul, div) on WIDTH-bit unsigned operands.
- Sequences a single shared adder/subtractor: one pass for add/sub, WIDTH iterations for shift-add multiply and restoring divide.
- Returns result, remainder and error with a start/busy/done handshake; sits between the keypad/op decoder and the display formatter.

Parameters:
- WIDTH, 10, operand width in bits; result is 2*WIDTH bits.
- CNT_W, 16, width of the optional completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  00 add, 01 sub, 10 mul, 11 div; captured with start.
- a  in  WIDTH  operand A / dividend; captured with start.
- b  in  WIDTH  operand B / divisor; captured with start.
- busy  out  1  high from the cycle after acceptance through the DONE cycle inclusive.
- done  out  1  one-cycle pulse; result, rem and err are valid from this cycle.
- result  out  2*WIDTH  sum, difference, product or quotient.
- rem  out  WIDTH  division remainder; 0 for other ops.
- err  out  1  divide-by-zero flag.
- op_count  out  CNT_W  completed operations (optional feature).

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE, busy=0, done=0, result=0, rem=0, err=0, op_count=0, iteration counter=0. A partial result is discarded.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - start=1 at edge 0 captures a, b and op; state goes to EXEC.
  - busy=1 from cycle 1.
  - start with busy=1 (EXEC or DONE) is ignored and not queued.
- Add/sub:
  - One EXEC cycle; done=1 in cycle 2.
  - Add: result = zero-extended a+b (max 2*(2^WIDTH-1)).
  - Sub: result = a-b as 2*WIDTH-bit two's complement, sign-extended. Example: 5-9 gives all ones except low bits ...1100.
- Mul:
  - Shift-add, LSB-first on b.
  - Exactly WIDTH EXEC cycles, using one shared adder operation per cycle; done in cycle WIDTH+1.
  - Product is exact, with no overflow.
- Div:
  - Restoring division, MSB-first; exactly WIDTH EXEC cycles; done in cycle WIDTH+1.
  - Quotient goes in the low WIDTH bits of result, upper bits 0; remainder goes to rem.
  - b=0: skip iteration, go to DONE after one EXEC cycle (done in cycle 2), err=1, result all ones, rem=a.
- DONE:
  - done=1 for exactly one cycle; returns to IDLE next cycle.
  - result, rem and err hold until the next accepted start, then clear to 0 in cycle 1.
- Only the shared adder/subtractor does arithmetic; no `*` or `/` operators.
- Iteration counter is $clog2(WIDTH+1) bits and counts down to 0.
- The op encoding is fully decoded; no illegal op exists.

Optional Feature:
- Macro: CALC_OP_COUNT_EN.
- Defined:
  - op_count increments by 1 in each DONE cycle, including err operations.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by rst_n.
- Undefined: the port is still present and tied to 0; no counter flops.

Test Plan (WIDTH=10):
- Add 1023+1023 at cycle 0 -> busy cycles 1-2, done cycle 2, result=2046, rem=0, err=0.
- Sub 5-9 -> done cycle 2, result=20'hFFFFC; then sub 9-5 -> result=4.
- Mul 1023*1023 -> done exactly cycle 11, result=1046529; start pulsed at cycle 4 is ignored and no second done follows.
- Div 1000/7 -> done cycle 11, result=142, rem=6, err=0. Div 37/0 -> done cycle 2, err=1, result=20'hFFFFF, rem=37.
- Reset: rst_n low at cycle 5 of a mul -> immediately busy=0 and result=0; after release, add 3+4 -> result=7 at cycle 2.
- With CALC_OP_COUNT_EN defined, CNT_W=2: five operations including one div-by-zero -> op_count 1,2,3,0,1. With the macro undefined -> op_count stays 0.
